// File: rtl/dice_roller_multi_if.sv
// Request/response bundle between game control (master) and the dice roller (slave).
// die_values is present only when DICE_HISTORY_EN is defined.
interface dice_roller_multi_if #(
  parameter int NUM_DICE = 4,
  parameter int OUT_W    = 8
);
  localparam int CW = $clog2(NUM_DICE + 1);

  logic [2:0]       die_select;
  logic [CW-1:0]    num_dice;
  logic             start;
  logic             busy;
  logic             done;
  logic             error;
  logic [OUT_W-1:0] rolled_sum;
  logic [4:0]       last_die;
`ifdef DICE_HISTORY_EN
  logic [NUM_DICE*5-1:0] die_values;
`endif

  modport master (
    output die_select, num_dice, start,
    input  busy, done, error, rolled_sum, last_die
`ifdef DICE_HISTORY_EN
    , input die_values
`endif
  );

  modport slave (
    input  die_select, num_dice, start,
    output busy, done, error, rolled_sum, last_die
`ifdef DICE_HISTORY_EN
    , output die_values
`endif
  );
endinterface

// File: rtl/dice_roller_multi.sv
// Multi-die roller: sums 1..NUM_DICE rejection-sampled dice; optional per-die history via DICE_HISTORY_EN.
// Latency: num_dice+1 cycles plus one per rejected candidate; invalid requests complete the next cycle.
// Backpressure: none; start is only sampled in IDLE and ignored while busy or done.
module dice_roller_multi #(
  parameter int                NUM_DICE = 4,
  parameter int                OUT_W    = 8,
  parameter int                LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] SEED     = 16'hACE1
) (
  input  logic               clock,
  input  logic               reset,
  dice_roller_multi_if.slave bus
);

  localparam int CW = $clog2(NUM_DICE + 1);

  if (NUM_DICE < 1) begin : g_bad_num_dice
    $error("dice_roller_multi: NUM_DICE must be at least 1");
  end
  if (longint'(NUM_DICE) * 20 > (longint'(1) << OUT_W) - 1) begin : g_bad_out_w
    $error("dice_roller_multi: NUM_DICE*20 does not fit in OUT_W bits");
  end
  if (LFSR_W != 16 && LFSR_W != 32) begin : g_bad_lfsr_w
    $error("dice_roller_multi: LFSR_W must be 16 or 32");
  end

  localparam logic [LFSR_W-1:0] TAPS      = (LFSR_W == 32) ? LFSR_W'(32'h80200003)
                                                           : LFSR_W'(16'hB400);
  localparam logic [LFSR_W-1:0] SEED_INIT = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam logic [CW-1:0]     MAX_N     = CW'(NUM_DICE);
  // Five shifts per clock so consecutive candidates are disjoint bit windows;
  // with single shifts a rejected pattern would bias the retry towards one face.
  localparam int                STEPS     = 5;

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q;
  logic [2:0]       sel_q, sel_d;
  logic [CW-1:0]    num_q, num_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] sum_q, sum_d;
  logic [4:0]       last_q, last_d;
  logic             err_q, err_d;
`ifdef DICE_HISTORY_EN
  logic [NUM_DICE*5-1:0] hist_q, hist_d;
`endif

  logic [4:0] sides;
  logic [4:0] mask;
  logic [4:0] candidate;
  logic [4:0] die;
  logic       accept;
  logic       req_ok;

  function automatic logic [LFSR_W-1:0] lfsr_adv(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] r;
    r = s;
    for (int i = 0; i < STEPS; i++) begin
      r = r[0] ? ((r >> 1) ^ TAPS) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    sides = 5'd20;
    mask  = 5'd31;
    case (sel_q)
      3'd0: begin sides = 5'd4;  mask = 5'd3;  end
      3'd1: begin sides = 5'd6;  mask = 5'd7;  end
      3'd2: begin sides = 5'd8;  mask = 5'd7;  end
      3'd3: begin sides = 5'd10; mask = 5'd15; end
      3'd4: begin sides = 5'd12; mask = 5'd15; end
      default: begin sides = 5'd20; mask = 5'd31; end
    endcase
  end

  assign candidate = lfsr_q[4:0] & mask;
  assign accept    = candidate < sides;
  assign die       = candidate + 5'd1;
  assign req_ok    = (bus.die_select <= 3'd5) && (bus.num_dice != '0) && (bus.num_dice <= MAX_N);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    last_d  = last_q;
    err_d   = err_q;
`ifdef DICE_HISTORY_EN
    hist_d  = hist_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (req_ok) begin
            state_d = ROLL;
            sel_d   = bus.die_select;
            num_d   = bus.num_dice;
            cnt_d   = '0;
            sum_d   = '0;
            err_d   = 1'b0;
`ifdef DICE_HISTORY_EN
            hist_d  = '0;
`endif
          end else begin
            state_d = DONE;
            sum_d   = '0;
            err_d   = 1'b1;
          end
        end
      end
      ROLL: begin
        if (cnt_q == num_q) begin
          state_d = DONE;
        end else if (accept) begin
          sum_d  = sum_q + OUT_W'(die);
          last_d = die;
          cnt_d  = cnt_q + CW'(1);
`ifdef DICE_HISTORY_EN
          hist_d[cnt_q*5 +: 5] = die;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_INIT;
      sel_q   <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
`ifdef DICE_HISTORY_EN
      hist_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_adv(lfsr_q);
      sel_q   <= sel_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      last_q  <= last_d;
      err_q   <= err_d;
`ifdef DICE_HISTORY_EN
      hist_q  <= hist_d;
`endif
    end
  end

  assign bus.busy       = (state_q == ROLL);
  assign bus.done       = (state_q == DONE);
  assign bus.error      = err_q;
  assign bus.rolled_sum = sum_q;
  assign bus.last_die   = last_q;
`ifdef DICE_HISTORY_EN
  assign bus.die_values = hist_q;
`endif

endmodule

// File: tb/tb_dice_roller_multi.sv
// Directed bench for dice_roller_multi: expected outcomes queued at request time,
// popped and checked (ranges, latency, handshake) when done arrives.
module tb_dice_roller_multi;
  localparam int ND = 4;
  localparam int OW = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dice_roller_multi_if #(.NUM_DICE(ND), .OUT_W(OW)) bus ();

  dice_roller_multi #(
    .NUM_DICE(ND),
    .OUT_W   (OW),
    .LFSR_W  (16),
    .SEED    (16'hACE1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic err;
    int   lo;
    int   hi;
    int   n;
    int   sides;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   face_cnt[7];
  int   bad_face  = 0;
  int   spurious  = 0;
  int   pulses    = 0;
  int   s_out;
  logic e_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sides_of(input logic [2:0] sel);
    case (sel)
      3'd0: return 4;
      3'd1: return 6;
      3'd2: return 8;
      3'd3: return 10;
      3'd4: return 12;
      3'd5: return 20;
      default: return 0;
    endcase
  endfunction

  task automatic roll(input logic [2:0] sel, input int n, output int sum_o, output logic err_o);
    exp_t e;
    int   k;
    logic b1;
    int   acc;
    logic [4:0] v;
    e.sides = sides_of(sel);
    e.err   = (e.sides == 0) || (n == 0) || (n > ND);
    e.n     = n;
    e.lo    = e.err ? 0 : n;
    e.hi    = e.err ? 0 : n * e.sides;
    @(negedge clock);
    bus.die_select = sel;
    bus.num_dice   = n[2:0];
    bus.start      = 1'b1;
    sb.push_back(e);
    @(negedge clock);
    bus.start = 1'b0;
    b1 = bus.busy;
    k  = 1;
    while (bus.done !== 1'b1 && k < 400) begin
      @(negedge clock);
      k++;
    end
    e = sb.pop_front();
    check("done_seen", {31'd0, bus.done}, 1);
    check("busy_after_start", {31'd0, b1}, {31'd0, !e.err});
    if (e.err) check("err_latency", k, 1);
    else       check("min_latency", {31'd0, k >= e.n + 1}, 1);
    check("error_flag", {31'd0, bus.error}, {31'd0, e.err});
    check("busy_low_at_done", {31'd0, bus.busy}, 0);
    check("sum_range", {31'd0, (int'(bus.rolled_sum) >= e.lo) && (int'(bus.rolled_sum) <= e.hi)}, 1);
    if (!e.err) begin
      check("last_die_range", {31'd0, (bus.last_die >= 5'd1) && (int'(bus.last_die) <= e.sides)}, 1);
      if (e.n == 1) check("single_sum_eq_last", {24'd0, bus.rolled_sum}, {27'd0, bus.last_die});
    end
`ifdef DICE_HISTORY_EN
    if (!e.err) begin
      acc = 0;
      for (int i = 0; i < ND; i++) begin
        v = bus.die_values[i*5 +: 5];
        acc += int'(v);
        if (i < e.n) check("slot_range", {31'd0, (v >= 5'd1) && (int'(v) <= e.sides)}, 1);
        else         check("slot_unused", {27'd0, v}, 0);
      end
      check("slot_sum", acc, {24'd0, bus.rolled_sum});
    end
`else
    acc = 0;
    v   = '0;
`endif
    sum_o = int'(bus.rolled_sum);
    err_o = bus.error;
    @(negedge clock);
    check("done_one_cycle", {31'd0, bus.done}, 0);
  endtask

  initial begin
    bus.die_select = '0;
    bus.num_dice   = '0;
    bus.start      = 1'b0;
    for (int i = 0; i < 7; i++) face_cnt[i] = 0;

    // reset held two cycles, then idle
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    check("rst_error", {31'd0, bus.error}, 0);
    check("rst_sum", {24'd0, bus.rolled_sum}, 0);
    check("rst_last", {27'd0, bus.last_die}, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) spurious++;
    end
    check("idle_no_activity", spurious, 0);
    check("idle_sum", {24'd0, bus.rolled_sum}, 0);
    check("idle_last", {27'd0, bus.last_die}, 0);

    // valid requests
    roll(3'b000, 1, s_out, e_out);
    roll(3'b101, 4, s_out, e_out);
    roll(3'b100, 3, s_out, e_out);
    roll(3'b011, 2, s_out, e_out);
    roll(3'b010, 4, s_out, e_out);

    // invalid requests
    roll(3'b110, 1, s_out, e_out);
    roll(3'b001, 0, s_out, e_out);
    roll(3'b111, 2, s_out, e_out);
    roll(3'b001, 5, s_out, e_out);
    roll(3'b001, 2, s_out, e_out);
    check("error_cleared", {31'd0, e_out}, 0);

    // start while busy is ignored
    @(negedge clock);
    bus.die_select = 3'b101;
    bus.num_dice   = 3'd4;
    bus.start      = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    bus.die_select = 3'b110;
    bus.num_dice   = 3'd0;
    bus.start      = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1) begin
        pulses++;
        check("busy_retry_error", {31'd0, bus.error}, 0);
        check("busy_retry_sum", {31'd0, (bus.rolled_sum >= 8'd4) && (bus.rolled_sum <= 8'd80)}, 1);
      end
    end
    check("busy_single_done", pulses, 1);

    // reset in the middle of a roll
    @(negedge clock);
    bus.die_select = 3'b101;
    bus.num_dice   = 3'd4;
    bus.start      = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    check("mid_busy_before", {31'd0, bus.busy}, 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_busy", {31'd0, bus.busy}, 0);
    check("mid_rst_done", {31'd0, bus.done}, 0);
    check("mid_rst_error", {31'd0, bus.error}, 0);
    check("mid_rst_sum", {24'd0, bus.rolled_sum}, 0);
    check("mid_rst_last", {27'd0, bus.last_die}, 0);
    reset   = 1'b0;
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.done !== 1'b0) spurious++;
    end
    check("mid_rst_no_done", spurious, 0);

    // d6 distribution over back-to-back rolls
    for (int i = 0; i < 1200; i++) begin
      roll(3'b001, 1, s_out, e_out);
      if (s_out >= 1 && s_out <= 6) face_cnt[s_out]++;
      else bad_face++;
    end
    check("d6_out_of_range", bad_face, 0);
    for (int f = 1; f <= 6; f++) begin
      check("d6_face_count", {31'd0, (face_cnt[f] >= 150) && (face_cnt[f] <= 250)}, 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
